// File: rtl/tiny_loader.sv
// -----------------------------------------------------------------------------
// tiny_loader
//
// Boot-image loader. It takes a byte stream (length N, N payload bytes, one
// checksum byte), writes the payload to memory from address 0 upward and then
// releases the core. Once the core runs, the memory bus belongs to the core.
// A length byte of 0 means a 256-byte image.
//
// All state changes on the FALLING edge of clk. nreset is asynchronous and
// active low.
//
// Ports
//   clk          clock; state changes on the falling edge
//   nreset       asynchronous active-low reset
//   start        load request (LEN is entered from IDLE, RUN or ERR)
//   s_valid      stream byte valid
//   s_data       stream byte
//   s_ready      loader can take a stream byte (LEN, DATA, SUM)
//   core_read    core bus read strobe   (used only in RUN)
//   core_write   core bus write strobe  (used only in RUN)
//   core_addr    core bus address       (used only in RUN)
//   core_wdata   core bus write data    (used only in RUN)
//   mem_read     memory read strobe
//   mem_write    memory write strobe
//   mem_addr     memory address
//   mem_wdata    memory write data
//   core_nreset  registered active-low core reset; high only in RUN
//   busy         load in progress
//   done         image loaded, core running
//   error        checksum mismatch
// -----------------------------------------------------------------------------
module tiny_loader (
   input  logic       clk,
   input  logic       nreset,
   input  logic       start,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   input  logic       core_read,
   input  logic       core_write,
   input  logic [7:0] core_addr,
   input  logic [7:0] core_wdata,
   output logic       mem_read,
   output logic       mem_write,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       core_nreset,
   output logic       busy,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN  = 3'd1,
      DATA = 3'd2,
      SUM  = 3'd3,
      RUN  = 3'd4,
      ERR  = 3'd5
   } state_t;

   state_t     state_reg, state_next;
   logic [7:0] len_reg, len_next;      // N as received; 0 stands for 256
   logic [7:0] addr_reg, addr_next;    // next payload write address
   logic [7:0] sum_reg, sum_next;      // running payload sum, modulo 256
   logic       core_nreset_reg;

   logic       in_stream;              // state accepts stream bytes
   logic [7:0] last_addr;              // address of the final payload byte

   assign in_stream = (state_reg == LEN) || (state_reg == DATA) || (state_reg == SUM);

   // N-1 with 8-bit wrap: N=0 gives 0xFF, so all 256 addresses are written.
   assign last_addr = len_reg - 8'd1;

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(negedge clk or negedge nreset) begin
      if (!nreset) begin
         state_reg       <= IDLE;
         len_reg         <= 8'd0;
         addr_reg        <= 8'd0;
         sum_reg         <= 8'd0;
         core_nreset_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         len_reg         <= len_next;
         addr_reg        <= addr_next;
         sum_reg         <= sum_next;
         // Follows the next state, so the core is released on the edge that
         // enters RUN and held in reset from the edge that leaves it.
         core_nreset_reg <= (state_next == RUN);
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic. With s_valid low every streaming state holds, so
   // arbitrary gaps in the stream are harmless. start matters only in IDLE,
   // RUN and ERR.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      len_next   = len_reg;
      addr_next  = addr_reg;
      sum_next   = sum_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = LEN;
            end
         end

         LEN: begin
            if (s_valid) begin
               len_next   = s_data;
               addr_next  = 8'd0;
               sum_next   = 8'd0;
               state_next = DATA;
            end
         end

         DATA: begin
            if (s_valid) begin
               addr_next = addr_reg + 8'd1;
               sum_next  = sum_reg + s_data;
               if (addr_reg == last_addr) begin
                  state_next = SUM;
               end
            end
         end

         SUM: begin
            // sum_reg already includes the final payload byte.
            if (s_valid) begin
               state_next = (s_data == sum_reg) ? RUN : ERR;
            end
         end

         RUN, ERR: begin
            if (start) begin
               state_next = LEN;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Memory bus. The loader writes only while a payload byte is offered in
   // DATA. In RUN the core owns the bus; otherwise the bus idles as a read of
   // address 0. A core read and write asserted together resolve to the write,
   // so the two strobes are never active at once.
   // -------------------------------------------------------------------------
   always_comb begin
      mem_read  = 1'b1;
      mem_write = 1'b0;
      mem_addr  = 8'd0;
      mem_wdata = 8'd0;

      if ((state_reg == DATA) && s_valid) begin
         mem_read  = 1'b0;
         mem_write = 1'b1;
         mem_addr  = addr_reg;
         mem_wdata = s_data;
      end else if (state_reg == RUN) begin
         mem_read  = core_read & ~core_write;
         mem_write = core_write;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
      end
   end

   // -------------------------------------------------------------------------
   // Status outputs
   // -------------------------------------------------------------------------
   assign s_ready     = in_stream;
   assign busy        = in_stream;
   assign done        = (state_reg == RUN);
   assign error       = (state_reg == ERR);
   assign core_nreset = core_nreset_reg;

endmodule
